// File: rtl/sar_logic_ctrl_if.sv
// rtl/sar_logic_ctrl_if.sv - signal bundle between the SAR controller and its analog/pad side
//
// Purpose
//   Groups the conversion handshake and analog-macro control signals of
//   sar_logic_ctrl into one interface so the controller and its neighbours
//   connect through a single port.
//
// Parameters
//   WIDTH      result / DAC code width (must match the controller's WIDTH)
//
// Signals (direction as seen from the controller, modport master)
//   start      in   request a conversion (level-sampled while idle)
//   comp_in    in   comparator output, 1 = Vin above the DAC trial level
//   sh_sample  out  sample-and-hold control, 1 = track, 0 = hold
//   comp_en_n  out  comparator enable, active-low
//   dac_code   out  trial code to the R2R DAC
//   result     out  last completed conversion
//   valid      out  one-cycle strobe when result updates
//   busy       out  conversion in progress
//
// Modports
//   master     the controller
//   slave      the analog macros / top-level glue driving start and comp_in

interface sar_logic_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             comp_in;
  logic             sh_sample;
  logic             comp_en_n;
  logic [WIDTH-1:0] dac_code;
  logic [WIDTH-1:0] result;
  logic             valid;
  logic             busy;

  modport master (
    input  start,
    input  comp_in,
    output sh_sample,
    output comp_en_n,
    output dac_code,
    output result,
    output valid,
    output busy
  );

  modport slave (
    output start,
    output comp_in,
    input  sh_sample,
    input  comp_en_n,
    input  dac_code,
    input  result,
    input  valid,
    input  busy
  );

endinterface

// File: rtl/sar_logic_ctrl.sv
// rtl/sar_logic_ctrl.sv - successive-approximation controller for the SAR ADC analog macros
//
// Purpose
//   Sequences one SAR conversion: holds the sample-and-hold in track mode for
//   SAMPLE_CYCLES, then resolves one bit per step MSB first. Each step drives
//   the trial code to the R2R DAC, waits SETTLE_CYCLES for the DAC to settle,
//   then enables the comparator for one cycle and keeps or drops the trial
//   bit. The finished word is presented on result with a one-cycle valid.
//
//   Start-to-valid latency: SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+1) + 1 cycles.
//
// Parameters
//   WIDTH          result / DAC code width (8 for the R2R DAC)
//   SAMPLE_CYCLES  cycles sh_sample stays high for acquisition (>= 1)
//   SETTLE_CYCLES  DAC settle cycles before each comparator read (>= 1)
//
// Build option
//   SAR_CONTINUOUS_EN  when defined, DONE goes straight back to SAMPLE while
//                      start is high, giving back-to-back conversions with no
//                      idle cycle. When undefined, DONE always returns to IDLE.
//
// Ports
//   clk   in   system clock, single domain
//   rst   in   asynchronous active-high reset
//   bus   sar_logic_ctrl_if.master: start/comp_in in; sh_sample, comp_en_n,
//         dac_code, result, valid, busy out (all outputs registered)

module sar_logic_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sar_logic_ctrl_if.master      bus
);

  // Illegal configurations stop elaboration rather than produce a
  // controller with a zero-length acquisition or settle window.
  if (WIDTH < 1) begin : g_bad_width
    $error("sar_logic_ctrl: WIDTH must be >= 1");
  end
  if (SAMPLE_CYCLES < 1) begin : g_bad_sample
    $error("sar_logic_ctrl: SAMPLE_CYCLES must be >= 1");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("sar_logic_ctrl: SETTLE_CYCLES must be >= 1");
  end

  localparam int SCW = $clog2(SAMPLE_CYCLES + 1);
  localparam int TCW = $clog2(SETTLE_CYCLES + 1);
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Counters run down to zero, so they are loaded with (cycles - 1).
  localparam logic [SCW-1:0] SMP_LOAD = SCW'(SAMPLE_CYCLES - 1);
  localparam logic [TCW-1:0] STL_LOAD = TCW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]  IDX_MSB  = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state;
  logic [SCW-1:0]   smp_cnt;
  logic [TCW-1:0]   stl_cnt;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] resolved;

  // Returns w with bit b forced high: the next trial code.
  function automatic logic [WIDTH-1:0] with_bit(input logic [WIDTH-1:0] w,
                                                input logic [IW-1:0]    b);
    logic [WIDTH-1:0] t;
    t    = w;
    t[b] = 1'b1;
    return t;
  endfunction

  // Working word with the bit under test replaced by the comparator decision.
  // comp_in is taken raw: the comparator is clocked by clk on the analog side.
  always_comb begin
    resolved      = work;
    resolved[idx] = bus.comp_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      smp_cnt       <= '0;
      stl_cnt       <= '0;
      idx           <= '0;
      work          <= '0;
      bus.sh_sample <= 1'b0;
      bus.comp_en_n <= 1'b1;
      bus.dac_code  <= '0;
      bus.result    <= '0;
      bus.valid     <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state         <= S_SAMPLE;
            bus.busy      <= 1'b1;
            bus.sh_sample <= 1'b1;
            bus.dac_code  <= '0;
            idx           <= IDX_MSB;
            work          <= '0;
            smp_cnt       <= SMP_LOAD;
          end
        end

        S_SAMPLE: begin
          if (smp_cnt == '0) begin
            // Hold the input and present the MSB trial code.
            state         <= S_SETTLE;
            bus.sh_sample <= 1'b0;
            bus.dac_code  <= with_bit(work, idx);
            stl_cnt       <= STL_LOAD;
          end else begin
            smp_cnt <= smp_cnt - SCW'(1);
          end
        end

        S_SETTLE: begin
          if (stl_cnt == '0) begin
            state         <= S_COMPARE;
            bus.comp_en_n <= 1'b0;
          end else begin
            stl_cnt <= stl_cnt - TCW'(1);
          end
        end

        S_COMPARE: begin
          work          <= resolved;
          bus.comp_en_n <= 1'b1;
          if (idx == '0) begin
            // Last bit resolved: publish the word in the DONE cycle.
            state        <= S_DONE;
            bus.result   <= resolved;
            bus.valid    <= 1'b1;
            bus.dac_code <= resolved;
          end else begin
            // Index only decrements while nonzero, so it never wraps.
            state        <= S_SETTLE;
            idx          <= idx - IW'(1);
            bus.dac_code <= with_bit(resolved, idx - IW'(1));
            stl_cnt      <= STL_LOAD;
          end
        end

        S_DONE: begin
`ifdef SAR_CONTINUOUS_EN
          if (bus.start) begin
            // Back-to-back conversion: skip IDLE, busy stays high.
            state         <= S_SAMPLE;
            bus.sh_sample <= 1'b1;
            bus.dac_code  <= '0;
            idx           <= IDX_MSB;
            work          <= '0;
            smp_cnt       <= SMP_LOAD;
          end else begin
            state        <= S_IDLE;
            bus.busy     <= 1'b0;
            bus.dac_code <= '0;
          end
`else
          state        <= S_IDLE;
          bus.busy     <= 1'b0;
          bus.dac_code <= '0;
`endif
        end

        default: begin
          state         <= S_IDLE;
          bus.busy      <= 1'b0;
          bus.sh_sample <= 1'b0;
          bus.comp_en_n <= 1'b1;
          bus.dac_code  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_logic_ctrl.sv
// tb/tb_sar_logic_ctrl.sv - scoreboard bench for sar_logic_ctrl (default and 3/2 timing instances)

`timescale 1ns/1ps

module tb_sar_logic_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sar_logic_ctrl_if #(.WIDTH(8)) bus_a ();
  sar_logic_ctrl_if #(.WIDTH(8)) bus_b ();

  // Comparator: 0 = Vin model, 1 = tied high, 2 = tied low.
  logic [1:0] cmp_mode = 2'd0;
  logic [7:0] vin_a    = 8'h00;
  logic [7:0] vin_b    = 8'h3C;

  assign bus_a.comp_in = (cmp_mode == 2'd1) ? 1'b1 :
                         (cmp_mode == 2'd2) ? 1'b0 : (vin_a >= bus_a.dac_code);
  assign bus_b.comp_in = (vin_b >= bus_b.dac_code);

  sar_logic_ctrl dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sar_logic_ctrl #(.WIDTH(8), .SAMPLE_CYCLES(3), .SETTLE_CYCLES(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

`ifdef SAR_CONTINUOUS_EN
  localparam int HELD_PERIOD = 19;
`else
  localparam int HELD_PERIOD = 20;
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] res;
    int         lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] trial_q[$];

  int cyc            = 0;
  int start_cyc      = 0;
  int valid_cnt      = 0;
  int last_valid_cyc = 0;
  int prev_valid_cyc = 0;
  int sh_run         = 0;
  int sh_len         = 0;
  bit trial_en       = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: trial codes at every comparator read, results on valid.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus_a.sh_sample) sh_run++;
      else if (sh_run != 0) begin
        sh_len = sh_run;
        sh_run = 0;
      end
      if (trial_en && !bus_a.comp_en_n) begin
        if (trial_q.size() == 0) chk("trial_underflow", trial_q.size(), 1);
        else chk("trial_code", bus_a.dac_code, trial_q.pop_front());
      end
      if (bus_a.valid) begin
        valid_cnt++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) chk("valid_underflow", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("result", bus_a.result, e.res);
          if (e.lat > 0) chk("latency", cyc - start_cyc + 1, e.lat);
        end
      end
    end
  end

  function automatic bit cmp_model(input logic [7:0] v, input logic [7:0] t);
    if (cmp_mode == 2'd1) return 1'b1;
    if (cmp_mode == 2'd2) return 1'b0;
    return (v >= t);
  endfunction

  task automatic push_conv(input logic [7:0] v, input int lat);
    logic [7:0] w;
    logic [7:0] t;
    exp_t       e;
    w = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      t    = w;
      t[i] = 1'b1;
      trial_q.push_back(t);
      if (cmp_model(v, t)) w = t;
    end
    e.res = (cmp_mode == 2'd1) ? 8'hFF : (cmp_mode == 2'd2) ? 8'h00 : v;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic start_pulse();
    @(negedge clk) bus_a.start = 1'b1;
    @(negedge clk) bus_a.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int n = 0; n < max_cycles; n++) begin
      @(negedge clk);
      #1;
      if (!bus_a.busy && exp_q.size() == 0) break;
    end
    chk("busy_end", bus_a.busy, 0);
    chk("pending_results", exp_q.size(), 0);
    chk("pending_trials", trial_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   base;
    int   got_lat;
    bit   seen;
    logic [7:0] a5_trials [8];

    bus_a.start = 1'b0;
    bus_b.start = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_sh_sample", bus_a.sh_sample, 0);
    chk("rst_comp_en_n", bus_a.comp_en_n, 1);
    chk("rst_dac_code",  bus_a.dac_code,  0);
    chk("rst_result",    bus_a.result,    0);
    chk("rst_valid",     bus_a.valid,     0);
    chk("rst_busy",      bus_a.busy,      0);
    rst = 1'b0;

    // Vin = 0xA5 with the reference trial sequence
    cmp_mode  = 2'd0;
    vin_a     = 8'hA5;
    a5_trials = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    foreach (a5_trials[i]) trial_q.push_back(a5_trials[i]);
    exp_q.push_back('{res: 8'hA5, lat: 19});
    start_pulse();
    wait_idle(60);
    chk("sh_sample_len", sh_len, 2);

    // Comparator tied high, then tied low
    cmp_mode = 2'd1;
    push_conv(8'h00, 19);
    start_pulse();
    wait_idle(60);
    cmp_mode = 2'd2;
    push_conv(8'h00, 19);
    start_pulse();
    wait_idle(60);

    // Second start mid-conversion is ignored
    cmp_mode = 2'd0;
    vin_a    = 8'h5A;
    base     = valid_cnt;
    push_conv(8'h5A, 19);
    start_pulse();
    for (int k = 2; k <= 19; k++) begin
      @(negedge clk);
      chk("busy_during", bus_a.busy, 1);
      if (k == 5) bus_a.start = 1'b1;
      if (k == 6) bus_a.start = 1'b0;
    end
    wait_idle(60);
    repeat (5) @(negedge clk);
    chk("no_requeue_busy", bus_a.busy, 0);
    chk("single_valid", valid_cnt - base, 1);

    // Reset mid-conversion discards the partial result
    trial_en = 1'b0;
    vin_a    = 8'h77;
    start_pulse();
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_sh_sample", bus_a.sh_sample, 0);
    chk("abort_comp_en_n", bus_a.comp_en_n, 1);
    chk("abort_dac_code",  bus_a.dac_code,  0);
    chk("abort_result",    bus_a.result,    0);
    chk("abort_valid",     bus_a.valid,     0);
    chk("abort_busy",      bus_a.busy,      0);
    @(negedge clk) rst = 1'b0;
    trial_en = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_result_after", bus_a.result, 0);
    chk("abort_busy_after",   bus_a.busy,   0);

    // Start held high: repeated conversions
    vin_a = 8'h33;
    base  = valid_cnt;
    push_conv(8'h33, 19);
    push_conv(8'h33, 0);
    push_conv(8'h33, 0);
    @(negedge clk) bus_a.start = 1'b1;
    @(negedge clk) start_cyc = cyc;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      #1;
      if (valid_cnt - base >= 3) break;
    end
    bus_a.start = 1'b0;
    chk("held_valids", valid_cnt - base, 3);
    chk("held_period", last_valid_cyc - prev_valid_cyc, HELD_PERIOD);
    wait_idle(60);

    // Slower timing instance: SAMPLE_CYCLES=3, SETTLE_CYCLES=2
    seen    = 1'b0;
    got_lat = 0;
    @(negedge clk) bus_b.start = 1'b1;
    @(negedge clk) bus_b.start = 1'b0;
    base = cyc;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (bus_b.valid) begin
        seen    = 1'b1;
        got_lat = cyc - base + 1;
        chk("b_result", bus_b.result, 8'h3C);
        break;
      end
    end
    chk("b_valid_seen", seen, 1);
    chk("b_latency", got_lat, 28);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
